// File: rtl/multisim_irq_collector.sv
// Purpose: debounce the multisim server's quasi-static irq/finish pulls, latch irq rising edges as sticky pending bits, and sequence finish after pending drains or a timeout expires.
// Latency: a new input value reaches o_irq_level (and sets pending) STABLE_CYCLES edges after the edge that captures it; an accepted ack clears pending on that same edge.
// Backpressure: o_ack_ready drops for one cycle after each accepted ack, so acks complete at most every other cycle; the irq inputs are never stalled.
// Optional: define MULTISIM_IRQ_COLLECTOR_STATS_EN to add the o_glitch_count output.
module multisim_irq_collector #(
  parameter int DATA_WIDTH    = 32,
  parameter int STABLE_CYCLES = 4,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_irq,
  input  logic                  i_finish,
  output logic [DATA_WIDTH-1:0] o_irq_level,
  output logic [DATA_WIDTH-1:0] o_irq_pending,
  output logic                  o_irq_any,
  input  logic                  i_ack_valid,
  input  logic [DATA_WIDTH-1:0] i_ack_mask,
  output logic                  o_ack_ready,
  output logic                  o_finish_req
`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
  ,
  output logic [31:0]           o_glitch_count
`endif
);

  localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
  localparam logic [7:0] STAB_SAT  = 8'(STABLE_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [0:0] {ACK_IDLE, ACK_HOLD} ack_state_t;
  typedef enum logic [1:0] {FIN_RUN, FIN_DRAIN, FIN_DONE} fin_state_t;

  logic [DATA_WIDTH-1:0] irq_sample_q, irq_sample_d;
  logic [7:0]            irq_cnt_q, irq_cnt_d;
  logic [DATA_WIDTH-1:0] irq_level_q, irq_level_d;
  logic                  irq_change;

  logic                  fin_sample_q, fin_sample_d;
  logic [7:0]            fin_cnt_q, fin_cnt_d;
  logic                  fin_stable_q, fin_stable_d;

  logic [DATA_WIDTH-1:0] pending_q, pending_d;
  logic                  any_q, any_d;

  ack_state_t            ack_state_q, ack_state_d;
  logic [DATA_WIDTH-1:0] ack_clear;

  fin_state_t            fin_state_q, fin_state_d;
  logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;

  // irq stability window: any change restarts it; the counter saturates once the value is accepted
  always_comb begin
    irq_sample_d = irq_sample_q;
    irq_cnt_d    = irq_cnt_q;
    irq_level_d  = irq_level_q;
    irq_change   = (i_irq != irq_sample_q);
    if (irq_change) begin
      irq_sample_d = i_irq;
      irq_cnt_d    = 8'd0;
    end else if (irq_cnt_q == STAB_LAST) begin
      irq_level_d  = irq_sample_q;
      irq_cnt_d    = STAB_SAT;
    end else if (irq_cnt_q < STAB_SAT) begin
      irq_cnt_d    = irq_cnt_q + 8'd1;
    end
  end

  // finish uses its own copy of the same stability window
  always_comb begin
    fin_sample_d = fin_sample_q;
    fin_cnt_d    = fin_cnt_q;
    fin_stable_d = fin_stable_q;
    if (i_finish != fin_sample_q) begin
      fin_sample_d = i_finish;
      fin_cnt_d    = 8'd0;
    end else if (fin_cnt_q == STAB_LAST) begin
      fin_stable_d = fin_sample_q;
      fin_cnt_d    = STAB_SAT;
    end else if (fin_cnt_q < STAB_SAT) begin
      fin_cnt_d    = fin_cnt_q + 8'd1;
    end
  end

  // ack handshake: accept in IDLE, then one dead HOLD cycle
  always_comb begin
    ack_state_d = ack_state_q;
    ack_clear   = '0;
    o_ack_ready = 1'b0;
    case (ack_state_q)
      ACK_IDLE: begin
        o_ack_ready = 1'b1;
        if (i_ack_valid) begin
          ack_clear   = i_ack_mask;
          ack_state_d = ACK_HOLD;
        end
      end
      ACK_HOLD: ack_state_d = ACK_IDLE;
      default:  ack_state_d = ACK_IDLE;
    endcase
  end

  // sticky pending: a rising edge of the filtered level beats a same-edge clear
  always_comb begin
    pending_d = (pending_q & ~ack_clear) | (irq_level_d & ~irq_level_q);
    any_d     = |pending_d;
  end

  // finish sequencing: wait for pending to drain or the drain timer to run out
  always_comb begin
    fin_state_d = fin_state_q;
    drain_cnt_d = drain_cnt_q;
    case (fin_state_q)
      FIN_RUN: begin
        if (fin_stable_q) begin
          fin_state_d = FIN_DRAIN;
          drain_cnt_d = '0;
        end
      end
      FIN_DRAIN: begin
        if (!fin_stable_q) begin
          fin_state_d = FIN_RUN;
          drain_cnt_d = '0;
        end else if ((pending_q == '0) || (drain_cnt_q == DRAIN_LAST)) begin
          fin_state_d = FIN_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      FIN_DONE: fin_state_d = FIN_DONE;
      default:  fin_state_d = FIN_RUN;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_sample_q <= '0;
      irq_cnt_q    <= 8'd0;
      irq_level_q  <= '0;
      fin_sample_q <= 1'b0;
      fin_cnt_q    <= 8'd0;
      fin_stable_q <= 1'b0;
      pending_q    <= '0;
      any_q        <= 1'b0;
      ack_state_q  <= ACK_IDLE;
      fin_state_q  <= FIN_RUN;
      drain_cnt_q  <= '0;
    end else begin
      irq_sample_q <= irq_sample_d;
      irq_cnt_q    <= irq_cnt_d;
      irq_level_q  <= irq_level_d;
      fin_sample_q <= fin_sample_d;
      fin_cnt_q    <= fin_cnt_d;
      fin_stable_q <= fin_stable_d;
      pending_q    <= pending_d;
      any_q        <= any_d;
      ack_state_q  <= ack_state_d;
      fin_state_q  <= fin_state_d;
      drain_cnt_q  <= drain_cnt_d;
    end
  end

  assign o_irq_level   = irq_level_q;
  assign o_irq_pending = pending_q;
  assign o_irq_any     = any_q;
  assign o_finish_req  = (fin_state_q == FIN_DONE);

`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
  logic [31:0] glitch_cnt_q, glitch_cnt_d;

  // count changes that arrive while a window is open but not yet accepted
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (irq_change && (irq_cnt_q != 8'd0) && (irq_cnt_q < STAB_SAT) &&
        (glitch_cnt_q != 32'hFFFF_FFFF)) begin
      glitch_cnt_d = glitch_cnt_q + 32'd1;
    end
  end

  // glitch counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) glitch_cnt_q <= 32'd0;
    else        glitch_cnt_q <= glitch_cnt_d;
  end

  assign o_glitch_count = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_multisim_irq_collector.sv
// Directed bench for multisim_irq_collector (STABLE_CYCLES=4, DRAIN_TIMEOUT=16).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_multisim_irq_collector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_irq;
  logic        i_finish;
  logic [31:0] o_irq_level;
  logic [31:0] o_irq_pending;
  logic        o_irq_any;
  logic        i_ack_valid;
  logic [31:0] i_ack_mask;
  logic        o_ack_ready;
  logic        o_finish_req;
`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
  logic [31:0] o_glitch_count;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  multisim_irq_collector #(
    .DATA_WIDTH   (32),
    .STABLE_CYCLES(4),
    .DRAIN_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_irq        (i_irq),
    .i_finish     (i_finish),
    .o_irq_level  (o_irq_level),
    .o_irq_pending(o_irq_pending),
    .o_irq_any    (o_irq_any),
    .i_ack_valid  (i_ack_valid),
    .i_ack_mask   (i_ack_mask),
    .o_ack_ready  (o_ack_ready),
    .o_finish_req (o_finish_req)
`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
    ,
    .o_glitch_count(o_glitch_count)
`endif
  );

  always #5 clk = ~clk;

  // advance n rising edges, then settle 1 unit
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // hold reset for two edges with the given irq value driven, release between edges
  task automatic do_reset(input logic [31:0] irq);
    rst_n       = 1'b0;
    i_irq       = irq;
    i_finish    = 1'b0;
    i_ack_valid = 1'b0;
    i_ack_mask  = 32'h0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    i_irq       = 32'hFFFF_FFFF;
    i_finish    = 1'b0;
    i_ack_valid = 1'b0;
    i_ack_mask  = 32'h0;
    tick(2);
    total_cnt++; if (o_irq_level !== 32'h0) $display("FAIL reset_level: got %h want %h", o_irq_level, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL reset_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_any !== 1'b0) $display("FAIL reset_any: got %b want 0", o_irq_any); else pass_cnt++;
    total_cnt++; if (o_ack_ready !== 1'b1) $display("FAIL reset_ack_ready: got %b want 1", o_ack_ready); else pass_cnt++;
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL reset_finish_req: got %b want 0", o_finish_req); else pass_cnt++;
`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
    total_cnt++; if (o_glitch_count !== 32'd0) $display("FAIL reset_glitch_count: got %0d want 0", o_glitch_count); else pass_cnt++;
`endif
    rst_n = 1'b1;
    // edge 1 captures FFFF_FFFF; it is accepted 4 edges after that capture
    tick(4);
    total_cnt++; if (o_irq_level !== 32'h0) $display("FAIL reset_level_early: got %h want %h", o_irq_level, 32'h0); else pass_cnt++;
    tick(1);
    total_cnt++; if (o_irq_level !== 32'hFFFF_FFFF) $display("FAIL reset_level_accept: got %h want %h", o_irq_level, 32'hFFFF_FFFF); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'hFFFF_FFFF) $display("FAIL reset_pending_set: got %h want %h", o_irq_pending, 32'hFFFF_FFFF); else pass_cnt++;
    total_cnt++; if (o_irq_any !== 1'b1) $display("FAIL reset_any_set: got %b want 1", o_irq_any); else pass_cnt++;
  endtask

  task automatic test_glitch();
    do_reset(32'h0);
    tick(6);
    i_irq = 32'h1;
    tick(3);
    i_irq = 32'h0;
    tick(8);
    total_cnt++; if (o_irq_level !== 32'h0) $display("FAIL glitch_level: got %h want %h", o_irq_level, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL glitch_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_any !== 1'b0) $display("FAIL glitch_any: got %b want 0", o_irq_any); else pass_cnt++;
`ifdef MULTISIM_IRQ_COLLECTOR_STATS_EN
    total_cnt++; if (o_glitch_count !== 32'd1) $display("FAIL glitch_count: got %0d want 1", o_glitch_count); else pass_cnt++;
`endif
  endtask

  task automatic test_edge_ack();
    do_reset(32'h0);
    i_irq = 32'h5;
    tick(5);
    total_cnt++; if (o_irq_pending !== 32'h5) $display("FAIL edge_pending: got %h want %h", o_irq_pending, 32'h5); else pass_cnt++;
    total_cnt++; if (o_irq_any !== 1'b1) $display("FAIL edge_any: got %b want 1", o_irq_any); else pass_cnt++;
    // first ack accepted; valid stays high with a new mask through the HOLD cycle
    i_ack_valid = 1'b1;
    i_ack_mask  = 32'h1;
    tick(1);
    total_cnt++; if (o_irq_pending !== 32'h4) $display("FAIL ack1_pending: got %h want %h", o_irq_pending, 32'h4); else pass_cnt++;
    total_cnt++; if (o_ack_ready !== 1'b0) $display("FAIL ack1_ready_low: got %b want 0", o_ack_ready); else pass_cnt++;
    i_ack_mask = 32'h4;
    tick(1);
    total_cnt++; if (o_irq_pending !== 32'h4) $display("FAIL hold_ignored: got %h want %h", o_irq_pending, 32'h4); else pass_cnt++;
    total_cnt++; if (o_ack_ready !== 1'b1) $display("FAIL hold_ready_back: got %b want 1", o_ack_ready); else pass_cnt++;
    tick(1);
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL ack2_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_any !== 1'b0) $display("FAIL ack2_any: got %b want 0", o_irq_any); else pass_cnt++;
    i_ack_valid = 1'b0;
    i_ack_mask  = 32'h0;
    tick(1);
    total_cnt++; if (o_ack_ready !== 1'b1) $display("FAIL ack2_ready_back: got %b want 1", o_ack_ready); else pass_cnt++;
  endtask

  task automatic test_collision();
    do_reset(32'h0);
    tick(6);
    i_irq = 32'h2;
    tick(4);
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL coll_pre_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    // ack for bit1 lands on the same edge bit1 rises
    i_ack_valid = 1'b1;
    i_ack_mask  = 32'h2;
    tick(1);
    total_cnt++; if (o_irq_pending !== 32'h2) $display("FAIL coll_set_wins: got %h want %h", o_irq_pending, 32'h2); else pass_cnt++;
    total_cnt++; if (o_ack_ready !== 1'b0) $display("FAIL coll_ack_taken: got %b want 0", o_ack_ready); else pass_cnt++;
    i_ack_valid = 1'b0;
    i_ack_mask  = 32'h0;
    // falling edge of the level leaves pending alone
    i_irq = 32'h0;
    tick(7);
    total_cnt++; if (o_irq_level !== 32'h0) $display("FAIL fall_level: got %h want %h", o_irq_level, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'h2) $display("FAIL fall_pending: got %h want %h", o_irq_pending, 32'h2); else pass_cnt++;
    // zero-mask ack: accepted, takes HOLD, clears nothing
    i_ack_valid = 1'b1;
    tick(1);
    total_cnt++; if (o_irq_pending !== 32'h2) $display("FAIL zero_ack_pending: got %h want %h", o_irq_pending, 32'h2); else pass_cnt++;
    total_cnt++; if (o_ack_ready !== 1'b0) $display("FAIL zero_ack_hold: got %b want 0", o_ack_ready); else pass_cnt++;
    i_ack_valid = 1'b0;
    tick(1);
  endtask

  task automatic test_finish_drain();
    do_reset(32'h0);
    i_irq = 32'h8;
    tick(6);
    total_cnt++; if (o_irq_pending !== 32'h8) $display("FAIL drain_pending: got %h want %h", o_irq_pending, 32'h8); else pass_cnt++;
    // finish captured on edge 1, stable after edge 5, DRAIN after edge 6
    i_finish = 1'b1;
    tick(8);
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL drain_wait: got %b want 0", o_finish_req); else pass_cnt++;
    i_ack_valid = 1'b1;
    i_ack_mask  = 32'h8;
    tick(1);
    i_ack_valid = 1'b0;
    i_ack_mask  = 32'h0;
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL drain_ack_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL drain_not_yet: got %b want 0", o_finish_req); else pass_cnt++;
    tick(1);
    total_cnt++; if (o_finish_req !== 1'b1) $display("FAIL drain_done: got %b want 1", o_finish_req); else pass_cnt++;
    i_finish = 1'b0;
    tick(8);
    total_cnt++; if (o_finish_req !== 1'b1) $display("FAIL drain_sticky: got %b want 1", o_finish_req); else pass_cnt++;
  endtask

  task automatic test_finish_timeout();
    do_reset(32'h0);
    i_irq = 32'h8;
    tick(6);
    // enter DRAIN, then withdraw finish so the block falls back to RUN
    i_finish = 1'b1;
    tick(10);
    i_finish = 1'b0;
    tick(8);
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL abort_drain: got %b want 0", o_finish_req); else pass_cnt++;
    // re-enter DRAIN after edge 6; timeout fires 16 edges later at edge 22
    i_finish = 1'b1;
    tick(21);
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL timeout_early: got %b want 0", o_finish_req); else pass_cnt++;
    tick(1);
    total_cnt++; if (o_finish_req !== 1'b1) $display("FAIL timeout_fire: got %b want 1", o_finish_req); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'h8) $display("FAIL timeout_pending: got %h want %h", o_irq_pending, 32'h8); else pass_cnt++;
    // asynchronous reset clears everything without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (o_finish_req !== 1'b0) $display("FAIL async_rst_finish: got %b want 0", o_finish_req); else pass_cnt++;
    total_cnt++; if (o_irq_pending !== 32'h0) $display("FAIL async_rst_pending: got %h want %h", o_irq_pending, 32'h0); else pass_cnt++;
    total_cnt++; if (o_irq_level !== 32'h0) $display("FAIL async_rst_level: got %h want %h", o_irq_level, 32'h0); else pass_cnt++;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_edge_ack();
    test_collision();
    test_finish_drain();
    test_finish_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
